// File: rtl/bit_serializer_piso_if.sv
// Word-in / bit-out bundle between a word producer and bit_serializer_piso.
// The master side supplies words and the per-bit enable. The slave side is the
// serializer, which returns the serial stream and its status flags.
interface bit_serializer_piso_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             en;
  logic             a;
  logic             a_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid, en,
    input  din_ready, a, a_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid, en,
    output din_ready, a, a_valid, word_done, busy
  );
endinterface

// File: rtl/bit_serializer_piso.sv
// Parallel-in/serial-out stage feeding the serial sequence detectors.
// WIDTH-bit words arrive on a valid/ready handshake and leave one bit per
// enabled clock on `a`, which is qualified by `a_valid`. A one-entry hold slot
// lets the next word start on the clock after the previous word's last bit.
// Outside a word, `a` is driven low so that a detector sampling every clock
// sees no spurious 1s.
module bit_serializer_piso #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 res,
  bit_serializer_piso_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;

  logic             take;
  logic             last_bit;
  logic             cur_bit;
  logic [WIDTH-1:0] shifted;

  // Ready is held low while reset is asserted, so no word is accepted during
  // reset. Otherwise ready is high whenever the hold slot can take a word.
  assign bus.din_ready = !hold_full && !res;
  assign take          = bus.din_valid && bus.din_ready;

  // The bit on the line is the outgoing end of the shift register. It is
  // masked to 0 when no word is active, so an idle line reads as zeros.
  assign cur_bit     = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign shifted     = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]}
                                 : {shreg[WIDTH-2:0], 1'b0};
  assign bus.a_valid = (state == SHIFT);
  assign bus.a       = cur_bit && bus.a_valid;

  // The final bit of a word is consumed this cycle.
  assign last_bit      = bus.a_valid && bus.en && (cnt == LAST);
  assign bus.word_done = last_bit;
  assign bus.busy      = (state == SHIFT) || hold_full;

  // Single FSM that handles word loading, bit shifting, the hold slot, and the
  // zero-gap reload at each word boundary.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shreg <= bus.din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            cnt <= '0;
            if (hold_full) begin
              shreg     <= hold;
              hold_full <= 1'b0;
            end else if (take) begin
              shreg <= bus.din;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end else begin
            if (bus.en) begin
              shreg <= shifted;
              cnt   <= cnt + 1'b1;
            end
            if (take) begin
              hold      <= bus.din;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer_piso.sv
// Self-checking bench for bit_serializer_piso. It runs an MSB-first instance
// and an LSB-first instance side by side on identical stimulus. A queue-based
// reference model tracks the pending bits of each instance and the number of
// bits left in each queued word.
module tb_bit_serializer_piso;

  localparam int W = 8;

  logic clk = 1'b0;
  logic res = 1'b1;

  int checks = 0;
  int errors = 0;

  bit mq_msb[$];
  bit mq_lsb[$];
  int mw[$];

  logic s_a0, s_a1, s_av0, s_av1, s_wd0, s_wd1;
  logic s_rdy0, s_rdy1, s_busy0, s_busy1;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e;
    logic         ea0;
    logic         ea1;
    logic         eav;
    logic         ewd;
  } vec_t;

  vec_t tbl[19];

  bit_serializer_piso_if #(.WIDTH(W)) if_msb ();
  bit_serializer_piso_if #(.WIDTH(W)) if_lsb ();

  bit_serializer_piso #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk (clk),
    .res (res),
    .bus (if_msb.slave)
  );

  bit_serializer_piso #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk (clk),
    .res (res),
    .bus (if_lsb.slave)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic e);
    if_msb.din_valid = v;
    if_msb.din       = d;
    if_msb.en        = e;
    if_lsb.din_valid = v;
    if_lsb.din       = d;
    if_lsb.en        = e;
  endtask

  task automatic sample();
    s_a0    = if_msb.a;
    s_av0   = if_msb.a_valid;
    s_wd0   = if_msb.word_done;
    s_rdy0  = if_msb.din_ready;
    s_busy0 = if_msb.busy;
    s_a1    = if_lsb.a;
    s_av1   = if_lsb.a_valid;
    s_wd1   = if_lsb.word_done;
    s_rdy1  = if_lsb.din_ready;
    s_busy1 = if_lsb.busy;
  endtask

  task automatic model_clear();
    mq_msb.delete();
    mq_lsb.delete();
    mw.delete();
  endtask

  // Drive one cycle of inputs (starting at a falling edge), compare against
  // the model, advance the model across the rising edge, and return at the
  // next falling edge.
  task automatic apply_stimulus(input logic v, input logic [W-1:0] d, input logic e);
    logic ev, ea0, ea1, ewd, erdy;
    drive(v, d, e);
    #1;
    sample();
    ev   = (mw.size() > 0);
    ea0  = ev ? mq_msb[0] : 1'b0;
    ea1  = ev ? mq_lsb[0] : 1'b0;
    ewd  = ev && e && (mw[0] == 1);
    erdy = (mw.size() < 2);
    check_output("m_a_msb",     32'(s_a0),    32'(ea0));
    check_output("m_a_lsb",     32'(s_a1),    32'(ea1));
    check_output("m_valid_msb", 32'(s_av0),   32'(ev));
    check_output("m_valid_lsb", 32'(s_av1),   32'(ev));
    check_output("m_done_msb",  32'(s_wd0),   32'(ewd));
    check_output("m_done_lsb",  32'(s_wd1),   32'(ewd));
    check_output("m_ready_msb", 32'(s_rdy0),  32'(erdy));
    check_output("m_ready_lsb", 32'(s_rdy1),  32'(erdy));
    check_output("m_busy_msb",  32'(s_busy0), 32'(ev));
    check_output("m_busy_lsb",  32'(s_busy1), 32'(ev));
    if (ev && e) begin
      void'(mq_msb.pop_front());
      void'(mq_lsb.pop_front());
      mw[0] = mw[0] - 1;
      if (mw[0] == 0) void'(mw.pop_front());
    end
    if (v && erdy) begin
      for (int i = 0; i < W; i++) begin
        mq_msb.push_back(d[W-1-i]);
        mq_lsb.push_back(d[i]);
      end
      mw.push_back(W);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise reset partway through a cycle and check that the outputs clear at
  // once. Release reset at the next falling edge.
  task automatic reset_now(input string tag);
    res = 1'b1;
    #1;
    sample();
    check_output({tag, "_a"},     32'(s_a0 | s_a1),       32'd0);
    check_output({tag, "_valid"}, 32'(s_av0 | s_av1),     32'd0);
    check_output({tag, "_busy"},  32'(s_busy0 | s_busy1), 32'd0);
    check_output({tag, "_done"},  32'(s_wd0 | s_wd1),     32'd0);
    check_output({tag, "_ready"}, 32'(s_rdy0 | s_rdy1),   32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    #1;
    sample();
    check_output({tag, "_ready_rel"}, 32'(s_rdy0 & s_rdy1), 32'd1);
    check_output({tag, "_valid_rel"}, 32'(s_av0 | s_av1),   32'd0);
  endtask

  // Main test sequence: reset, directed table, corner sequences, then random.
  initial begin
    logic [15:0] pat;
    logic [3:0]  det;
    int          hits;
    int          done_cnt;

    tbl[0]  = '{1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    sample();
    check_output("rst_a",     32'(s_a0 | s_a1),       32'd0);
    check_output("rst_valid", 32'(s_av0 | s_av1),     32'd0);
    check_output("rst_busy",  32'(s_busy0 | s_busy1), 32'd0);
    check_output("rst_ready", 32'(s_rdy0 | s_rdy1),   32'd0);
    @(negedge clk);
    res = 1'b0;
    #1;
    sample();
    check_output("rel_ready", 32'(s_rdy0 & s_rdy1), 32'd1);
    @(negedge clk);

    // Directed table: 8'hB0, one idle cycle, then 8'h0D, both orders.
    det  = 4'd0;
    hits = 0;
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(tbl[i].v, tbl[i].d, tbl[i].e);
      check_output($sformatf("tbl%0d_a_msb", i), 32'(s_a0),  32'(tbl[i].ea0));
      check_output($sformatf("tbl%0d_a_lsb", i), 32'(s_a1),  32'(tbl[i].ea1));
      check_output($sformatf("tbl%0d_valid", i), 32'(s_av0), 32'(tbl[i].eav));
      check_output($sformatf("tbl%0d_done", i),  32'(s_wd0), 32'(tbl[i].ewd));
      if (s_av0) begin
        det = {det[2:0], s_a0};
        if (det == 4'b1011) hits++;
      end
    end
    check_output("detector_hits", 32'(hits), 32'd1);

    // Back-to-back: the second word goes into the hold slot and streams with no gap.
    pat      = 16'hB0BB;
    done_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      apply_stimulus(c < 2, (c == 0) ? 8'hB0 : 8'hBB, 1'b1);
      if (c >= 1 && c <= 16) begin
        check_output($sformatf("b2b_bit%0d", c),   32'(s_a0),  32'(pat[16-c]));
        check_output($sformatf("b2b_valid%0d", c), 32'(s_av0), 32'd1);
      end
      if (c >= 2 && c <= 8) check_output($sformatf("b2b_ready%0d", c), 32'(s_rdy0), 32'd0);
      if (c == 9)           check_output("b2b_ready9", 32'(s_rdy0), 32'd1);
      if (s_wd0) begin
        check_output($sformatf("b2b_done_cycle%0d", c), 32'((c == 8) || (c == 16)), 32'd1);
        done_cnt++;
      end
    end
    check_output("b2b_done_count", 32'(done_cnt), 32'd2);

    // Stall: en is low on cycles 3..5, so bit index 2 stays on the line.
    done_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      apply_stimulus(c == 0, 8'hB0, !(c >= 3 && c <= 5));
      if (c >= 3 && c <= 6) check_output($sformatf("stall_hold%0d", c), 32'(s_a0), 32'd1);
      if (s_wd0) begin
        check_output("stall_done_cycle", 32'(c), 32'd11);
        done_cnt++;
      end
    end
    check_output("stall_done_count", 32'(done_cnt), 32'd1);

    // Reset in the middle of 8'hFF while 8'h5A sits in the hold slot.
    apply_stimulus(1'b1, 8'hFF, 1'b1);
    apply_stimulus(1'b1, 8'h5A, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("mid_busy_before", 32'(s_busy0), 32'd1);
    reset_now("midrst");
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      apply_stimulus(c == 0, 8'h96, 1'b1);
      if (c == 1) begin
        check_output("post_rst_first_msb", 32'(s_a0), 32'd1);
        check_output("post_rst_first_lsb", 32'(s_a1), 32'd0);
      end
      if (c == 8) check_output("post_rst_done", 32'(s_wd0), 32'd1);
    end

    // Idle line: en toggles, no words offered.
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(1'b0, 8'($urandom), 1'($urandom));
      check_output($sformatf("idle%0d", c), 32'({s_a0, s_av0, s_wd0, s_a1}), 32'd0);
    end

    // Random traffic checked only against the model.
    for (int c = 0; c < 400; c++) begin
      apply_stimulus(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
